// File: rtl/alu_result_display_pkg.sv
// alu_result_display_pkg: shared states, digit codes and active-low segment patterns
package alu_result_display_pkg;
  typedef enum logic [1:0] {IDLE, CONVERT, SHOW} state_t;
  typedef logic [3:0] digit_t;
  localparam digit_t DIG_ONE   = 4'd1;
  localparam digit_t DIG_E     = 4'hA;
  localparam digit_t DIG_R     = 4'hB;
  localparam digit_t DIG_BLANK = 4'hF;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
endpackage

// File: rtl/alu_result_display_seg7_decoder.sv
// seg7_decoder: digit code to active-low {g,f,e,d,c,b,a} pattern
module seg7_decoder
  import alu_result_display_pkg::*;
(
  input  digit_t     code,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:  seg = SEG_0;
      4'd1:  seg = SEG_1;
      4'd2:  seg = SEG_2;
      4'd3:  seg = SEG_3;
      4'd4:  seg = SEG_4;
      4'd5:  seg = SEG_5;
      4'd6:  seg = SEG_6;
      4'd7:  seg = SEG_7;
      4'd8:  seg = SEG_8;
      4'd9:  seg = SEG_9;
      DIG_E: seg = SEG_E;
      DIG_R: seg = SEG_R;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/alu_result_display.sv
// alu_result_display: captures {remainder, quotient} and scans it onto a 4-digit common-anode display
module alu_result_display
  import alu_result_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       res_valid,
  input  logic [7:0] res_data,
  input  logic       div_by_zero,
  output logic       res_ready,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [7:0]       cap;
  logic             cap_dz;
  digit_t           dig [4];
  digit_t           nd [4];
  logic [6:0]       cur_seg;
  logic [3:0]       q, r;
  logic             xfer, wrap;
  assign xfer = res_valid && res_ready;
  assign wrap = cnt == CNT_W'(REFRESH_DIV - 1);
  assign q = cap[3:0];
  assign r = cap[7:4];
  // tens is either blank or 1 since values never exceed 15
  always_comb begin
    nd[3] = cap_dz ? DIG_E : (q > 4'd9 ? DIG_ONE : DIG_BLANK);
    nd[2] = cap_dz ? DIG_R : (q > 4'd9 ? q - 4'd10 : q);
    nd[1] = cap_dz ? DIG_R : (r > 4'd9 ? DIG_ONE : DIG_BLANK);
    nd[0] = cap_dz ? DIG_BLANK : (r > 4'd9 ? r - 4'd10 : r);
  end
  seg7_decoder u_dec (.code(dig[idx]), .seg(cur_seg));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      cap       <= '0;
      cap_dz    <= 1'b0;
      dig       <= '{default: DIG_BLANK};
      res_ready <= 1'b1;
      an        <= 4'hF;
      seg       <= SEG_BLANK;
      dp        <= 1'b1;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      idx <= wrap ? idx + 2'd1 : idx;
      an  <= state == IDLE ? 4'hF : ~(4'b0001 << idx);
      seg <= state == IDLE ? SEG_BLANK : cur_seg;
      dp  <= 1'b1;
      if (state == CONVERT) begin
        dig       <= nd;
        state     <= SHOW;
        res_ready <= 1'b1;
      end else if (xfer) begin
        cap       <= res_data;
        cap_dz    <= div_by_zero;
        state     <= CONVERT;
        res_ready <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_result_display.sv
// tb_alu_result_display: directed checks of handshake, digit mapping, Err display and async reset
module tb_alu_result_display;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       res_valid = 1'b0;
  logic [7:0] res_data = '0;
  logic       div_by_zero = 1'b0;
  logic       res_ready;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  int passed = 0;
  int total = 0;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S5 = 7'b0010010, S6 = 7'b0000010, SE = 7'b0000110, SR = 7'b0101111;
  localparam logic [6:0] SB = 7'b1111111;

  alu_result_display #(.REFRESH_DIV(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .res_data(res_data),
    .div_by_zero(div_by_zero), .res_ready(res_ready), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic transfer(input string tag, input logic [7:0] d, input logic dz);
    res_valid = 1'b1;
    res_data = d;
    div_by_zero = dz;
    @(negedge clk);
    check({tag, "_ready_low"}, 32'(res_ready), 32'd0);
    res_valid = 1'b0;
    res_data = 8'h55;
    div_by_zero = 1'b0;
    @(negedge clk);
    check({tag, "_ready_back"}, 32'(res_ready), 32'd1);
  endtask

  task automatic scan(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                      input logic [6:0] e1, input logic [6:0] e0);
    logic [3:0] seen = '0;
    repeat (3) @(negedge clk);
    repeat (16) begin
      @(negedge clk);
      check({tag, "_an_onehot"}, 32'($countones(~an)), 32'd1);
      check({tag, "_dp"}, 32'(dp), 32'd1);
      case (an)
        4'b0111: begin seen[3] = 1'b1; check({tag, "_d3"}, 32'(seg), 32'(e3)); end
        4'b1011: begin seen[2] = 1'b1; check({tag, "_d2"}, 32'(seg), 32'(e2)); end
        4'b1101: begin seen[1] = 1'b1; check({tag, "_d1"}, 32'(seg), 32'(e1)); end
        4'b1110: begin seen[0] = 1'b1; check({tag, "_d0"}, 32'(seg), 32'(e0)); end
        default: ;
      endcase
    end
    check({tag, "_all_digits"}, 32'(seen), 32'hF);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("idle_an", 32'(an), 32'hF);
      check("idle_seg", 32'(seg), 32'h7F);
      check("idle_dp", 32'(dp), 32'd1);
      check("idle_ready", 32'(res_ready), 32'd1);
    end
    transfer("t2", 8'h16, 1'b0);
    scan("t2", SB, S6, SB, S1);
    transfer("t3", 8'h0F, 1'b0);
    scan("t3", S1, S5, SB, S0);
    transfer("t4", 8'hAB, 1'b1);
    scan("t4", SE, SR, SR, SB);
    // hold valid through CONVERT: first beat ignored, second beat captured
    res_valid = 1'b1;
    res_data = 8'h45;
    @(negedge clk);
    check("t5_ready_low", 32'(res_ready), 32'd0);
    res_data = 8'h23;
    @(negedge clk);
    check("t5_ready_high", 32'(res_ready), 32'd1);
    @(negedge clk);
    check("t5_ready_low2", 32'(res_ready), 32'd0);
    res_valid = 1'b0;
    res_data = 8'h00;
    @(negedge clk);
    check("t5_ready_back", 32'(res_ready), 32'd1);
    scan("t5", SB, S3, SB, S2);
    res_valid = 1'b1;
    res_data = 8'h16;
    @(negedge clk);
    res_valid = 1'b0;
    check("t6_in_convert", 32'(res_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_an", 32'(an), 32'hF);
    check("t6_rst_seg", 32'(seg), 32'h7F);
    check("t6_rst_dp", 32'(dp), 32'd1);
    check("t6_rst_ready", 32'(res_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      check("t6_idle_an", 32'(an), 32'hF);
      check("t6_idle_ready", 32'(res_ready), 32'd1);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/alu_result_display.md
Name: alu_result_display

Overview:
Downstream stage of the 4-bit ALU divide path. Captures the packed 8-bit {remainder, quotient} result through a valid/ready handshake and converts each 4-bit field to two decimal digits. Drives a 4-digit, common-anode, time-multiplexed seven-segment display. Shows "Err" when the divide-by-zero flag accompanies the result.

Parameters:
REFRESH_DIV, 50000, clock cycles each digit stays active before the scan advances (minimum 2).
CNT_W, 16, width of the refresh counter; must hold REFRESH_DIV-1.

Ports:
clk  in  1  system clock, single clock domain
rst_n  in  1  asynchronous active-low reset
res_valid  in  1  result on res_data/div_by_zero is valid this cycle
res_data  in  8  [7:4] remainder, [3:0] quotient, both unsigned 0..15
div_by_zero  in  1  divisor was zero; qualified by res_valid
res_ready  out  1  block can accept a result this cycle
an  out  4  digit enables, active-low, one-hot-low; an[3] is the leftmost digit
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low, always 1 (off)

Behaviour:
- One clock; reset is asynchronous and active-low.
- All outputs are registered.
- Reset values: an=4'b1111, seg=7'h7F, dp=1, res_ready=1, state=IDLE, scan index=0, refresh counter=0, digit registers=blank.
- State machine has three states:
  - IDLE: display blanked (an=1111), res_ready=1. A transfer (res_valid && res_ready at a rising edge) moves to CONVERT.
  - CONVERT: lasts exactly 1 cycle. res_ready=0. The captured result is converted into four digit codes, then the state moves to SHOW.
  - SHOW: res_ready=1 and the display is scanned. A new transfer moves to CONVERT; the old digits keep being shown until CONVERT writes the new ones.
- Capture: res_data and div_by_zero are latched only on a transfer. res_valid while res_ready=0 is ignored and not queued; the upstream stage must hold it.
- Latency: transfer at edge N, digit registers updated at edge N+1, new pattern visible from edge N+2 on whichever digit is then active.
- Digit mapping for a normal result:
  - an[3] = quotient tens, an[2] = quotient units.
  - an[1] = remainder tens, an[0] = remainder units.
  - Values are 0..15. A tens digit of 0 is blanked; the units digit is always shown, so 0 displays as " 0".
- Divide-by-zero: digits 3..0 show E, r, r, blank, regardless of res_data.
- Segment codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - E=0000110, r=0101111, blank=1111111
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1 and then wraps to 0.
  - On each wrap, the scan index advances 0→1→2→3→0.
  - In SHOW: an=~(4'b0001<<index), and seg is the code of that digit, updated on the same edge as an.
  - The counter and index run in all states; an is forced to 1111 in IDLE.
- Simultaneous events: a transfer on the same edge as a counter wrap is fine; the scan advances normally and the new digits appear at edge N+2.
- Reset mid-operation (any state, including CONVERT) returns everything to reset values immediately; the captured result is discarded.

Decomposition:
- Shared package holds:
  - state enum {IDLE, CONVERT, SHOW};
  - segment code constants SEG_0..SEG_9, SEG_E, SEG_R, SEG_BLANK;
  - digit code typedef (4-bit: 0..9, E, r, blank).
- One natural sub-module: seg7_decoder, a combinational map from digit code to a 7-bit active-low pattern.
- The 0..15 to tens/units split stays inline: tens = (v>9), units = v-10 when v>9, otherwise v.

Test Plan (REFRESH_DIV=4):
1. Reset held, then released → an=1111, seg=7F, dp=1, res_ready=1 for 20 cycles, no digit enabled.
2. Transfer res_data=8'h16 (13/2: quotient 6, remainder 1), div_by_zero=0 → res_ready=0 for exactly one cycle; after one full scan: an=0111 seg=7F, an=1011 seg=0000010, an=1101 seg=7F, an=1110 seg=1111001.
3. Transfer 8'h0F (15/1) → digit3=1111001, digit2=0010010, digit1=7F, digit0=1000000.
4. Transfer with div_by_zero=1, res_data=8'hAB → digits show 0000110, 0101111, 0101111, 1111111; res_data is ignored.
5. During the CONVERT cycle, hold res_valid with 8'h23 → not captured that cycle; captured on the next cycle when res_ready=1; the display ends showing quotient 3, remainder 2.
6. Assert rst_n=0 during CONVERT → outputs return to reset values asynchronously, before the next clock edge; after release, state is IDLE and the display is blank.
